// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between decode and the RV32IM execute unit.
// The master side issues operations and the slave side returns results.
interface alu_exec_unit_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [1:0]      alu_op;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [4:0]      alu_ctrl;
    logic [XLEN-1:0] result;
    logic            zero;
    logic            busy;
    logic            done;

    modport master (
        output start, alu_op, funct3, funct7, a, b,
        input  alu_ctrl, result, zero, busy, done
    );

    modport slave (
        input  start, alu_op, funct3, funct7, a, b,
        output alu_ctrl, result, zero, busy, done
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Registered RV32IM execute unit: ALU-control decode, single-cycle ALU/MUL,
// and a 32-iteration restoring divider behind a start/busy/done handshake.
module alu_exec_unit #(
    parameter int XLEN       = 32,
    parameter int DIV_CYCLES = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_exec_unit_if.slave     bus
);
    localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_AND = 5'd2,
                           OP_OR  = 5'd3,  OP_XOR = 5'd4,  OP_SLL = 5'd5,
                           OP_SRL = 5'd6,  OP_SRA = 5'd7,  OP_SLT = 5'd8,
                           OP_SLTU = 5'd9, OP_MUL = 5'd10, OP_MULH = 5'd11,
                           OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14,
                           OP_DIVU = 5'd15, OP_REM = 5'd16, OP_REMU = 5'd17;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_DIV  = 1'b1;

    localparam int CNT_W = $clog2(DIV_CYCLES);

    logic [4:0]      ctrl;
    logic [XLEN-1:0] alu_out;
    logic [63:0]     prod_ss, prod_su, prod_uu;
    logic [0:0]      state;
    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0] quo, rem, dvs, a_save;
    logic            is_rem, neg_q, neg_r, dbz;
    logic [XLEN:0]   rem_sh, diff;
    logic            ge, last;
    logic [XLEN-1:0] quo_nxt, rem_nxt, q_fin, r_fin, div_res;
    logic            is_div_op, sgn_div, a_neg, b_neg;

    // NOTE: every signal written in always_comb gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        ctrl = OP_ADD;
        unique case (bus.alu_op)
            2'b00: ctrl = OP_ADD;
            2'b01: ctrl = OP_SUB;
            default: begin
                if (bus.alu_op == 2'b10 && bus.funct7 == 7'b0000001) begin
                    // M-extension codes are laid out in funct3 order from MUL.
                    ctrl = OP_MUL + {2'b00, bus.funct3};
                end else begin
                    unique case (bus.funct3)
                        3'b000: ctrl = (bus.alu_op == 2'b10 && bus.funct7[5]) ? OP_SUB : OP_ADD;
                        3'b001: ctrl = OP_SLL;
                        3'b010: ctrl = OP_SLT;
                        3'b011: ctrl = OP_SLTU;
                        3'b100: ctrl = OP_XOR;
                        3'b101: ctrl = bus.funct7[5] ? OP_SRA : OP_SRL;
                        3'b110: ctrl = OP_OR;
                        default: ctrl = OP_AND;
                    endcase
                end
            end
        endcase
    end

    assign bus.alu_ctrl = ctrl;

    // Operands extended to 64 bits so one truncated product covers each signedness mix.
    assign prod_ss = {{32{bus.a[31]}}, bus.a} * {{32{bus.b[31]}}, bus.b};
    assign prod_su = {{32{bus.a[31]}}, bus.a} * {32'b0, bus.b};
    assign prod_uu = {32'b0, bus.a} * {32'b0, bus.b};

    always_comb begin
        alu_out = '0;
        unique case (ctrl)
            OP_ADD:    alu_out = bus.a + bus.b;
            OP_SUB:    alu_out = bus.a - bus.b;
            OP_AND:    alu_out = bus.a & bus.b;
            OP_OR:     alu_out = bus.a | bus.b;
            OP_XOR:    alu_out = bus.a ^ bus.b;
            OP_SLL:    alu_out = bus.a << bus.b[4:0];
            OP_SRL:    alu_out = bus.a >> bus.b[4:0];
            OP_SRA:    alu_out = $signed(bus.a) >>> bus.b[4:0];
            OP_SLT:    alu_out = {31'b0, $signed(bus.a) < $signed(bus.b)};
            OP_SLTU:   alu_out = {31'b0, bus.a < bus.b};
            OP_MUL:    alu_out = prod_uu[31:0];
            OP_MULH:   alu_out = prod_ss[63:32];
            OP_MULHSU: alu_out = prod_su[63:32];
            OP_MULHU:  alu_out = prod_uu[63:32];
            default:   alu_out = '0;
        endcase
    end

    assign is_div_op = (ctrl >= OP_DIV);
    assign sgn_div   = (ctrl == OP_DIV) || (ctrl == OP_REM);
    assign a_neg     = sgn_div && bus.a[31];
    assign b_neg     = sgn_div && bus.b[31];

    // One restoring step: the dividend shifts out of quo into rem, quotient bits shift in.
    assign rem_sh  = {rem, quo[XLEN-1]};
    assign diff    = rem_sh - {1'b0, dvs};
    assign ge      = ~diff[XLEN];
    assign rem_nxt = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
    assign quo_nxt = {quo[XLEN-2:0], ge};
    assign q_fin   = neg_q ? -quo_nxt : quo_nxt;
    assign r_fin   = neg_r ? -rem_nxt : rem_nxt;
    assign div_res = dbz ? (is_rem ? a_save : '1) : (is_rem ? r_fin : q_fin);
    assign last    = (cnt == CNT_W'(DIV_CYCLES - 1));

    assign bus.busy = (state == ST_DIV);

    // NOTE: all state here is updated with non-blocking assignments so every
    // register samples values from before the edge, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            quo        <= '0;
            rem        <= '0;
            dvs        <= '0;
            a_save     <= '0;
            is_rem     <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            dbz        <= 1'b0;
            bus.result <= '0;
            bus.zero   <= 1'b1;
            bus.done   <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        if (is_div_op) begin
                            state  <= ST_DIV;
                            cnt    <= '0;
                            quo    <= a_neg ? -bus.a : bus.a;
                            dvs    <= b_neg ? -bus.b : bus.b;
                            rem    <= '0;
                            a_save <= bus.a;
                            is_rem <= (ctrl >= OP_REM);
                            neg_q  <= a_neg ^ b_neg;
                            neg_r  <= a_neg;
                            dbz    <= (bus.b == '0);
                        end else begin
                            bus.result <= alu_out;
                            bus.zero   <= (alu_out == '0);
                            bus.done   <= 1'b1;
                        end
                    end
                end
                default: begin
                    quo <= quo_nxt;
                    rem <= rem_nxt;
                    cnt <= cnt + CNT_W'(1);
                    if (last) begin
                        state      <= ST_IDLE;
                        bus.result <= div_res;
                        bus.zero   <= (div_res == '0);
                        bus.done   <= 1'b1;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed, table-driven bench for alu_exec_unit plus hand-written
// sequences for reset, back-to-back issue and divider interruption.
module tb_alu_exec_unit;
    logic clk;
    logic rst_n;

    alu_exec_unit_if #(.XLEN(32)) bus ();

    alu_exec_unit #(.XLEN(32), .DIV_CYCLES(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  ctrl;
        logic [31:0] res;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Waits for done after a divide start edge; returns edges elapsed (bounded).
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (bus.done !== 1'b1 && cycles < 40) begin
            @(posedge clk);
            #1;
            cycles++;
        end
    endtask

    task automatic drive(input logic [1:0] op, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [31:0] a, input logic [31:0] b);
        bus.alu_op = op;
        bus.funct3 = f3;
        bus.funct7 = f7;
        bus.a      = a;
        bus.b      = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int cyc;
        int dones;
        logic [31:0] held;

        vecs[0]  = '{2'b10, 3'b000, 7'h00, 32'd31,        32'd6,        5'd0,  32'd37};
        vecs[1]  = '{2'b10, 3'b000, 7'h20, 32'd31,        32'd6,        5'd1,  32'd25};
        vecs[2]  = '{2'b10, 3'b101, 7'h00, 32'hF000_0000, 32'd4,        5'd6,  32'h0F00_0000};
        vecs[3]  = '{2'b10, 3'b101, 7'h20, 32'hF000_0000, 32'd4,        5'd7,  32'hFF00_0000};
        vecs[4]  = '{2'b10, 3'b010, 7'h00, 32'hFFFF_FFFF, 32'd1,        5'd8,  32'd1};
        vecs[5]  = '{2'b10, 3'b011, 7'h00, 32'hFFFF_FFFF, 32'd1,        5'd9,  32'd0};
        vecs[6]  = '{2'b10, 3'b111, 7'h00, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd2, 32'h0F00_0F00};
        vecs[7]  = '{2'b10, 3'b110, 7'h00, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd3, 32'hFF0F_FF0F};
        vecs[8]  = '{2'b10, 3'b100, 7'h00, 32'hFF00_FF00, 32'h0F0F_0F0F, 5'd4, 32'hF00F_F00F};
        vecs[9]  = '{2'b10, 3'b001, 7'h00, 32'd1,         32'd31,       5'd5,  32'h8000_0000};
        vecs[10] = '{2'b00, 3'b111, 7'h20, 32'd5,         32'd7,        5'd0,  32'd12};
        vecs[11] = '{2'b01, 3'b000, 7'h00, 32'd5,         32'd5,        5'd1,  32'd0};
        vecs[12] = '{2'b11, 3'b000, 7'h20, 32'd31,        32'd6,        5'd0,  32'd37};
        vecs[13] = '{2'b11, 3'b101, 7'h20, 32'hF000_0000, 32'd4,        5'd7,  32'hFF00_0000};
        vecs[14] = '{2'b10, 3'b000, 7'h01, 32'd31,        32'd6,        5'd10, 32'd186};
        vecs[15] = '{2'b10, 3'b001, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11, 32'd0};
        vecs[16] = '{2'b10, 3'b010, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd12, 32'hFFFF_FFFF};
        vecs[17] = '{2'b10, 3'b011, 7'h01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd13, 32'hFFFF_FFFE};
        vecs[18] = '{2'b10, 3'b100, 7'h01, 32'd31,        32'd6,        5'd14, 32'd5};
        vecs[19] = '{2'b10, 3'b110, 7'h01, 32'd31,        32'd6,        5'd16, 32'd1};
        vecs[20] = '{2'b10, 3'b100, 7'h01, 32'hFFFF_FFE1, 32'd6,        5'd14, 32'hFFFF_FFFB};
        vecs[21] = '{2'b10, 3'b110, 7'h01, 32'hFFFF_FFE1, 32'd6,        5'd16, 32'hFFFF_FFFF};
        vecs[22] = '{2'b10, 3'b100, 7'h01, 32'd7,         32'd0,        5'd14, 32'hFFFF_FFFF};
        vecs[23] = '{2'b10, 3'b111, 7'h01, 32'd7,         32'd0,        5'd17, 32'd7};
        vecs[24] = '{2'b10, 3'b100, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000};
        vecs[25] = '{2'b10, 3'b110, 7'h01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16, 32'd0};
        vecs[26] = '{2'b10, 3'b101, 7'h01, 32'd100,       32'd7,        5'd15, 32'd14};

        // Reset state, then hold with start low after release.
        rst_n     = 1'b0;
        bus.start = 1'b0;
        drive(2'b00, 3'b000, 7'h00, 32'd1, 32'd2);
        repeat (3) @(posedge clk);
        #1;
        check("reset result", bus.result, 32'd0);
        check("reset zero",   {31'b0, bus.zero}, 32'd1);
        check("reset busy",   {31'b0, bus.busy}, 32'd0);
        check("reset done",   {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("idle result", bus.result, 32'd0);
        check("idle zero",   {31'b0, bus.zero}, 32'd1);
        check("idle done",   {31'b0, bus.done}, 32'd0);

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i].op, vecs[i].f3, vecs[i].f7, vecs[i].a, vecs[i].b);
            #1;
            check($sformatf("vec%0d alu_ctrl", i), {27'b0, bus.alu_ctrl}, {27'b0, vecs[i].ctrl});
            bus.start = 1'b1;
            @(posedge clk);
            #1;
            bus.start = 1'b0;
            if (vecs[i].ctrl >= 5'd14) begin
                check($sformatf("vec%0d busy after start", i), {31'b0, bus.busy}, 32'd1);
                check($sformatf("vec%0d no early done", i), {31'b0, bus.done}, 32'd0);
                wait_done(cyc);
                check($sformatf("vec%0d divide latency", i), cyc, 32'd32);
                check($sformatf("vec%0d busy at done", i), {31'b0, bus.busy}, 32'd0);
            end else begin
                check($sformatf("vec%0d done", i), {31'b0, bus.done}, 32'd1);
                check($sformatf("vec%0d busy", i), {31'b0, bus.busy}, 32'd0);
            end
            check($sformatf("vec%0d result", i), bus.result, vecs[i].res);
            check($sformatf("vec%0d zero", i), {31'b0, bus.zero}, {31'b0, vecs[i].res == 32'd0});
            @(posedge clk);
            #1;
            check($sformatf("vec%0d done pulse ends", i), {31'b0, bus.done}, 32'd0);
            check($sformatf("vec%0d result holds", i), bus.result, vecs[i].res);
        end

        // Back-to-back single-cycle issues: done on consecutive cycles.
        @(negedge clk);
        drive(2'b00, 3'b000, 7'h00, 32'd1, 32'd2);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        check("b2b first done",   {31'b0, bus.done}, 32'd1);
        check("b2b first result", bus.result, 32'd3);
        drive(2'b00, 3'b000, 7'h00, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("b2b second done",   {31'b0, bus.done}, 32'd1);
        check("b2b second result", bus.result, 32'd7);

        // Start pulsed mid-division must be ignored; inputs change while busy.
        @(negedge clk);
        drive(2'b10, 3'b100, 7'h01, 32'd31, 32'd6);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        held = bus.result;
        repeat (10) @(posedge clk);
        @(negedge clk);
        drive(2'b00, 3'b000, 7'h00, 32'd1, 32'd1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check("ignored start no done", {31'b0, bus.done}, 32'd0);
        check("ignored start busy",    {31'b0, bus.busy}, 32'd1);
        check("ignored start result",  bus.result, held);
        cyc = 11;
        dones = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("mid-start div latency", cyc, 32'd32);
        check("mid-start div result",  bus.result, 32'd5);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        check("single done pulse", dones, 32'd0);

        // Reset asserted at iteration 10 aborts the divide with no done.
        @(negedge clk);
        drive(2'b10, 3'b100, 7'h01, 32'd31, 32'd6);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort busy",   {31'b0, bus.busy}, 32'd0);
        check("abort result", bus.result, 32'd0);
        check("abort zero",   {31'b0, bus.zero}, 32'd1);
        check("abort done",   {31'b0, bus.done}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        check("no done after abort", dones, 32'd0);

        // Standalone decode checks.
        @(negedge clk);
        drive(2'b01, 3'b111, 7'h01, 32'd0, 32'd0);
        #1;
        check("decode alu_op=01", {27'b0, bus.alu_ctrl}, 32'd1);
        drive(2'b11, 3'b000, 7'h20, 32'd0, 32'd0);
        #1;
        check("decode I-type f3=000 funct7[5]", {27'b0, bus.alu_ctrl}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
